// File: rtl/led_pkg.sv
// Shared types and helpers for the board LED display arbiter and its round-robin picker.
package led_pkg;

    typedef enum logic [1:0] {IDLE, ARB, SHOW} arb_state_e;

    typedef logic [7:0] led_pattern_t;

    function automatic led_pattern_t LED_OFF(input logic polarity);
        return polarity ? 8'h00 : 8'hFF;
    endfunction

    function automatic int MS_PRESCALE(input int clk_in_mhz);
        return clk_in_mhz * 1000;
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping; zero latency.
module led_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last,
    output logic         o_found,
    output logic [W-1:0] o_next
);

    always_comb begin
        int w_cand;
        w_cand  = 0;
        o_found = 1'b0;
        o_next  = i_last;
        // Offset N revisits i_last itself, so a lone requester can be re-granted.
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(i_last) + k) % N;
            if (!o_found && i_req[W'(w_cand)]) begin
                o_found = 1'b1;
                o_next  = W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin share of the 8-LED display with minimum dwell; display_o lags pattern_i by 1 cycle.
// `SIM makes 1 ms = 1 cycle; `LED_DIM_PWM_EN adds brightness_i PWM dimming.
module led_display_arbiter
    import led_pkg::*;
#(
    parameter int   NUM_REQ      = 4,
    parameter int   CLK_IN_MHZ   = 125,
    parameter int   DWELL_MS     = 2000,
    parameter logic LED_POLARITY = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*8-1:0]       pattern_i,
`ifdef LED_DIM_PWM_EN
    input  logic [3:0]                 brightness_i,
`endif
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] active_idx_o,
    output logic                       dwell_done_o,
    output logic [7:0]                 display_o
);

    localparam int           IW    = $clog2(NUM_REQ);
    localparam led_pattern_t OFF   = LED_OFF(LED_POLARITY);
    localparam logic [15:0]  DWELL = 16'(DWELL_MS);

    arb_state_e   r_state;
    arb_state_e   w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [15:0]  r_dwell;
    led_pattern_t r_disp;

    logic          w_ms_tick;
    logic          w_found;
    logic [IW-1:0] w_pick_idx;
    logic          w_dwell_done;
    logic          w_req_act;
    logic          w_other_req;
    logic [NUM_REQ-1:0] w_onehot;
    led_pattern_t  w_pat;
    led_pattern_t  w_pat_lit;

`ifdef SIM
    assign w_ms_tick = 1'b1;
`else
    localparam int PRE = MS_PRESCALE(CLK_IN_MHZ);
    localparam int PW  = $clog2(PRE);
    logic [PW-1:0] r_pre;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)             r_pre <= '0;
        else if (w_ms_tick)      r_pre <= '0;
        else                     r_pre <= r_pre + 1'b1;
    end

    assign w_ms_tick = (r_pre == PW'(PRE - 1));
`endif

    led_rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
        .i_req   (req_i),
        .i_last  (r_idx),
        .o_found (w_found),
        .o_next  (w_pick_idx)
    );

    assign w_onehot     = NUM_REQ'(1) << r_idx;
    assign w_req_act    = |(req_i & w_onehot);
    assign w_other_req  = |(req_i & ~w_onehot);
    assign w_dwell_done = (r_dwell == DWELL);
    assign w_pat        = pattern_i[{r_idx, 3'b000} +: 8];
    assign w_pat_lit    = LED_POLARITY ? w_pat : ~w_pat;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // A dropped request wins over dwell expiry: the source no longer wants the display.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (|req_i) w_state_nxt = ARB;
            ARB:     w_state_nxt = w_found ? SHOW : IDLE;
            SHOW:    if (!w_req_act || (w_dwell_done && w_other_req)) w_state_nxt = ARB;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_o        = '0;
        dwell_done_o = 1'b0;
        if (r_state == SHOW) begin
            gnt_o        = w_onehot;
            dwell_done_o = w_dwell_done;
        end
    end

    // Display holds through ARB so a switch never flashes the LEDs off.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_idx   <= IW'(NUM_REQ - 1);
            r_dwell <= '0;
            r_disp  <= OFF;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_disp  <= OFF;
                    r_dwell <= '0;
                end
                ARB: begin
                    if (w_found) begin
                        r_idx   <= w_pick_idx;
                        r_dwell <= '0;
                    end
                end
                SHOW: begin
                    r_disp <= w_pat_lit;
                    if (w_dwell_done && w_req_act && !w_other_req)
                        r_dwell <= '0;
                    else if (w_ms_tick && !w_dwell_done)
                        r_dwell <= r_dwell + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign active_idx_o = r_idx;

`ifdef LED_DIM_PWM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_pwm <= '0;
        else         r_pwm <= r_pwm + 4'd1;
    end

    // Unlit LEDs already equal OFF, so blanking the whole word only dims lit ones.
    assign display_o = (r_pwm < brightness_i) ? r_disp : OFF;
`else
    assign display_o = r_disp;
`endif

endmodule

// File: tb/tb_led_display_arbiter.sv
// Self-checking bench for led_display_arbiter: NUM_REQ=4, DWELL_MS=4, active-low LEDs.
module tb_led_display_arbiter;

    localparam int N  = 4;
    localparam int DW = 4;
`ifdef SIM
    localparam int P  = 1;
`else
    localparam int P  = 1000;
`endif
    localparam int RR_BOUND = 4 * (DW * P + 3) + 20;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [N-1:0]  req_i;
    logic [N*8-1:0] pattern_i;
    logic [N-1:0]  gnt_o;
    logic [1:0]    active_idx_o;
    logic          dwell_done_o;
    logic [7:0]    display_o;
`ifdef LED_DIM_PWM_EN
    logic [3:0]    brightness_i;
`endif

    led_display_arbiter #(
        .NUM_REQ      (N),
        .CLK_IN_MHZ   (1),
        .DWELL_MS     (DW),
        .LED_POLARITY (1'b0)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .req_i        (req_i),
        .pattern_i    (pattern_i),
`ifdef LED_DIM_PWM_EN
        .brightness_i (brightness_i),
`endif
        .gnt_o        (gnt_o),
        .active_idx_o (active_idx_o),
        .dwell_done_o (dwell_done_o),
        .display_o    (display_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;
    logic [3:0] pwm_m = 4'd0;
    int sb[$];

    typedef struct {
        int         idx;
        logic [7:0] pat;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[5];

    task automatic tick();
        @(posedge clk_i);
        if (rstn_i) pwm_m = pwm_m + 4'd1;
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d required %0d..%0d", nm, act, lo, hi);
    endtask

    function automatic logic [7:0] pat_of(input int k);
        return pattern_i[k*8 +: 8];
    endfunction

    function automatic logic [7:0] exp_d(input logic [7:0] e);
`ifdef LED_DIM_PWM_EN
        return (pwm_m < brightness_i) ? e : 8'hFF;
`else
        return e;
`endif
    endfunction

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] prev;
        int ngr, slen, gap, cur, zeros, e;
        bit seen;

        tbl[0] = '{0, 8'hA5, 8'h5A};
        tbl[1] = '{1, 8'h3C, 8'hC3};
        tbl[2] = '{2, 8'h00, 8'hFF};
        tbl[3] = '{3, 8'hFF, 8'h00};
        tbl[4] = '{0, 8'h81, 8'h7E};

        rstn_i    = 1'b0;
        req_i     = '0;
        pattern_i = 32'hDEADBEEF;
`ifdef LED_DIM_PWM_EN
        brightness_i = 4'd15;
`endif
        #12;
        chk("rst_display", display_o, 8'hFF);
        chk("rst_gnt", gnt_o, 0);
        chk("rst_idx", active_idx_o, 3);
        chk("rst_dwell", dwell_done_o, 0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_gnt", gnt_o, 0);
            chk("idle_display", display_o, 8'hFF);
        end

        // Single-source vectors: grant latency, display mux/polarity, hold, ARB hold, release.
        for (int v = 0; v < 5; v++) begin
            pattern_i = 32'hDEADBEEF;
            pattern_i[tbl[v].idx*8 +: 8] = tbl[v].pat;
            req_i = N'(1) << tbl[v].idx;
            tick(); tick();
            chk("vec_gnt", gnt_o, N'(1) << tbl[v].idx);
            chk("vec_idx", active_idx_o, tbl[v].idx);
            tick();
            chk("vec_display", display_o, exp_d(tbl[v].exp));
            for (int h = 0; h < 3; h++) tick();
            chk("vec_hold", display_o, exp_d(tbl[v].exp));
            req_i = '0;
            tick();
            chk("vec_drop_gnt", gnt_o, 0);
            chk("vec_arb_display", display_o, exp_d(tbl[v].exp));
            tick(); tick();
            chk("vec_off", display_o, exp_d(8'hFF));
        end

        // Two steady requesters: alternating grants, dwell length, single-cycle gap.
        pattern_i = {8'h0F, 8'h3C, 8'h77, 8'hA5};
        sb.push_back(2); sb.push_back(0); sb.push_back(2); sb.push_back(0);
        req_i = 4'b0101;
        prev = '0; ngr = 0; slen = 0; gap = 0; cur = 0;
        for (int c = 0; c < RR_BOUND && ngr < 4; c++) begin
            tick();
            g = gnt_o;
            if (g != 0 && prev == 0) begin
                if (ngr > 0) chk("rr_gap", gap, 1);
                cur = sb.pop_front();
                chk("rr_gnt", g, N'(1) << cur);
                ngr++;
                slen = 1;
            end else if (g != 0) begin
                slen++;
            end else if (prev != 0) begin
                chk_rng("rr_show_len", slen, (DW - 1) * P + 2, DW * P + 1);
                chk("rr_arb_display", display_o, exp_d(~pat_of(cur)));
                gap = 1;
            end else begin
                gap++;
            end
            prev = g;
        end
        chk("rr_grants", ngr, 4);
        sb.delete();

        req_i = '0;
        for (int i = 0; i < 5; i++) tick();

        // Granted source drops early: switch without waiting for dwell.
        req_i = 4'b0100;
        tick(); tick();
        chk("drop_gnt2", gnt_o, 4'b0100);
        tick();
        req_i = 4'b1000;
        sb.push_back(3);
        tick();
        chk("drop_gap", gnt_o, 0);
        tick();
        e = sb.pop_front();
        chk("drop_gnt3", gnt_o, N'(1) << e);

        // Lone source: dwell completes, window restarts, grant kept.
        seen = 1'b0;
        for (int c = 0; c < DW * P + 5 && !seen; c++) begin
            tick();
            seen = dwell_done_o;
        end
        chk("stay_dwell_done", seen, 1);
        chk("stay_gnt", gnt_o, 4'b1000);
        tick();
        chk("stay_restart", dwell_done_o, 0);
        chk("stay_gnt_kept", gnt_o, 4'b1000);

        // Asynchronous reset in the middle of SHOW.
        req_i = 4'b0010;
        tick(); tick();
        chk("pre_rst_gnt", gnt_o, 4'b0010);
        tick();
        chk("pre_rst_display", display_o, exp_d(8'h88));
        rstn_i = 1'b0;
        pwm_m = 4'd0;
        #1;
        chk("async_rst_gnt", gnt_o, 0);
        chk("async_rst_display", display_o, 8'hFF);
        chk("async_rst_idx", active_idx_o, 3);
        tick();
        rstn_i = 1'b1;
        req_i = 4'b1111;
        sb.push_back(0);
        tick(); tick();
        e = sb.pop_front();
        chk("post_rst_gnt", gnt_o, N'(1) << e);
        tick();
        chk("post_rst_display", display_o, exp_d(8'h5A));

        req_i = 4'b0001;
        pattern_i[7:0] = 8'h01;
        tick(); tick();
`ifdef LED_DIM_PWM_EN
        brightness_i = 4'd4;
        zeros = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("pwm_display", display_o, exp_d(8'hFE));
            if (display_o[0] == 1'b0) zeros++;
        end
        chk("pwm_lit_cycles", zeros, 4);
`else
        zeros = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("full_display", display_o, 8'hFE);
            if (display_o[0] == 1'b0) zeros++;
        end
        chk("full_lit_cycles", zeros, 16);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
